// File: rtl/spi_bus_master_pkg.sv
// Shared definitions for the SPI bus master: register map, status bit
// positions and shift-engine state encoding.
package spi_bus_master_pkg;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_DATA = 2'd1;
   localparam logic [1:0] REG_DIV  = 2'd2;
   localparam logic [1:0] REG_SSEL = 2'd3;

   localparam int BIT_IE   = 0;
   localparam int BIT_OVR  = 1;
   localparam int BIT_DONE = 2;
   localparam int BIT_BUSY = 3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_LOW  = 3'd2,
      S_HIGH = 3'd3,
      S_DONE = 3'd4
   } eng_state_t;

endpackage

// File: rtl/spi_bus_master_if.sv
// CPU-side bus strobes for the SPI master; the tristate data bus stays a
// plain inout on the top so it can resolve against the RAM_B devices.
interface spi_bus_master_if;
   logic       cs;
   logic       oe;
   logic [3:0] we;
   logic [1:0] address;

   modport master (output cs, oe, we, address);
   modport slave  (input  cs, oe, we, address);
endinterface

// File: rtl/spi_bus_master_shift_engine.sv
// SPI mode-0 shift engine: divider, LOAD/LOW/HIGH/DONE FSM, shift register.
// start to done-state exit is 2 + 16*(div+1) clk cycles; start ignored unless idle.
module spi_shift_engine
   import spi_bus_master_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           tx,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 miso,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           rx
);

   localparam logic [DIV_WIDTH-1:0] ONE = 1;

   eng_state_t           state_q, state_d;
   logic [DIV_WIDTH-1:0] divcnt_q, div_q;
   logic [2:0]           bitcnt_q;
   logic [7:0]           shreg_q;
   logic                 sclk_q, mosi_q;
   logic                 phase_end;

   always_comb begin
      state_d   = state_q;
      phase_end = (divcnt_q == div_q);
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  state_d = S_LOW;
         S_LOW:   if (phase_end) state_d = S_HIGH;
         S_HIGH:  if (phase_end) state_d = (bitcnt_q == 3'd7) ? S_DONE : S_LOW;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         divcnt_q <= '0;
         div_q    <= '0;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         // The divisor is latched per phase so a mid-transfer CLKDIV write
         // only takes hold at the next phase boundary.
         if (state_d != state_q) begin
            divcnt_q <= '0;
            div_q    <= div;
         end else if (state_q == S_LOW || state_q == S_HIGH) begin
            divcnt_q <= divcnt_q + ONE;
         end
         case (state_q)
            S_LOAD: begin
               shreg_q  <= tx;
               mosi_q   <= tx[7];
               bitcnt_q <= '0;
            end
            S_LOW: if (phase_end) begin
               shreg_q <= {shreg_q[6:0], miso};
               sclk_q  <= 1'b1;
            end
            S_HIGH: if (phase_end) begin
               sclk_q <= 1'b0;
               if (bitcnt_q != 3'd7) begin
                  mosi_q   <= shreg_q[7];
                  bitcnt_q <= bitcnt_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign rx   = shreg_q;

endmodule

// File: rtl/spi_bus_master.sv
// Memory-mapped SPI master: register file, bus decode/tristate read and irq.
// Reads are combinational; a DATA write while busy is dropped and flags OVR.
module spi_bus_master
   import spi_bus_master_pkg::*;
#(
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 4,
   parameter int NUM_SS      = 4
) (
   input  logic              clk,
   input  logic              rst,
   spi_bus_master_if.slave   bus,
   inout  wire  [31:0]       data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n,
   output logic              irq
);

   logic                 ie_q, ovr_q, done_q;
   logic [7:0]           rx_q, tx_q, eng_rx;
   logic [DIV_WIDTH-1:0] div_q;
   logic [NUM_SS-1:0]    ssel_q;
   logic                 busy, eng_done;
   logic                 rd_en, wr_ctrl, wr_data, start;
   logic [31:0]          rd_dat;

   assign rd_en   = bus.cs & bus.oe & ~|bus.we;
   assign wr_ctrl = bus.cs & bus.we[0] & (bus.address == REG_CTRL);
   assign wr_data = bus.cs & bus.we[0] & (bus.address == REG_DATA);
   assign start   = wr_data & ~busy;

   always_comb begin
      rd_dat = '0;
      case (bus.address)
         REG_CTRL: begin
            rd_dat[BIT_IE]   = ie_q;
            rd_dat[BIT_OVR]  = ovr_q;
            rd_dat[BIT_DONE] = done_q;
            rd_dat[BIT_BUSY] = busy;
         end
         REG_DATA: rd_dat[7:0]           = rx_q;
         REG_DIV:  rd_dat[DIV_WIDTH-1:0] = div_q;
         REG_SSEL: rd_dat[NUM_SS-1:0]    = ssel_q;
         default:  ;
      endcase
   end

   assign data = rd_en ? rd_dat : 'z;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ie_q   <= 1'b0;
         ovr_q  <= 1'b0;
         done_q <= 1'b0;
         rx_q   <= '0;
         tx_q   <= '0;
         div_q  <= DIV_WIDTH'(DEFAULT_DIV);
         ssel_q <= '0;
      end else begin
         if (wr_ctrl) ie_q <= data[BIT_IE];
         // Sets take priority over W1C / read-clear landing on the same edge.
         if (wr_data & busy)                  ovr_q <= 1'b1;
         else if (wr_ctrl & data[BIT_OVR])    ovr_q <= 1'b0;
         if (eng_done) begin
            done_q <= 1'b1;
            rx_q   <= eng_rx;
         end else if ((wr_ctrl & data[BIT_DONE]) |
                      (rd_en & (bus.address == REG_DATA))) begin
            done_q <= 1'b0;
         end
         if (start) tx_q <= data[7:0];
         for (int i = 0; i < DIV_WIDTH; i++)
            if (bus.cs && bus.we[i/8] && bus.address == REG_DIV) div_q[i] <= data[i];
         for (int i = 0; i < NUM_SS; i++)
            if (bus.cs && bus.we[i/8] && bus.address == REG_SSEL) ssel_q[i] <= data[i];
      end
   end

   spi_shift_engine #(.DIV_WIDTH(DIV_WIDTH)) u_engine (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .tx    (tx_q),
      .div   (div_q),
      .miso  (miso),
      .sclk  (sclk),
      .mosi  (mosi),
      .busy  (busy),
      .done  (eng_done),
      .rx    (eng_rx)
   );

   assign ss_n = ~ssel_q;
   assign irq  = done_q & ie_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Scoreboard bench for spi_bus_master: stimulus pushes expected bus reads and
// pin snapshots; a negedge monitor pops and compares when a read or snapshot occurs.
module tb_spi_bus_master;

   logic       clk;
   logic       rst;
   logic       miso;
   logic       sclk, mosi, irq;
   logic [3:0] ss_n;
   wire  [31:0] data;
   logic [31:0] tb_wdat;
   logic       tb_drv;
   logic       pin_smp;
   int         miso_mode;

   typedef struct {
      string       name;
      bit          is_pin;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  checks;
   int  failures;

   spi_bus_master_if bus();

   spi_bus_master #(.DIV_WIDTH(16), .DEFAULT_DIV(4), .NUM_SS(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .data (data),
      .sclk (sclk),
      .mosi (mosi),
      .miso (miso),
      .ss_n (ss_n),
      .irq  (irq)
   );

   assign data = tb_drv ? tb_wdat : 'z;
   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pw(input logic i, input logic s, input logic m,
                                      input logic [3:0] n);
      return {25'd0, i, s, m, n};
   endfunction

   always @(negedge clk) begin
      logic        rd;
      logic [31:0] act;
      sb_t         e;
      rd = bus.cs & bus.oe & ~|bus.we;
      if (rd || pin_smp) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: act=%h required an expected entry", rd ? data : 32'd0);
         end else begin
            e   = sb_q.pop_front();
            act = pin_smp ? pw(irq, sclk, mosi, ss_n) : data;
            if (e.is_pin != pin_smp || act !== e.exp) begin
               failures++;
               $display("FAIL %s: act=%h exp=%h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
      bus.cs = 1'b1; bus.we = w; bus.address = a; tb_wdat = d; tb_drv = 1'b1;
      tick();
      bus.cs = 1'b0; bus.we = 4'd0; tb_drv = 1'b0;
   endtask

   task automatic bus_read(input string nm, input logic [1:0] a, input logic [31:0] exp);
      sb_q.push_back('{name: nm, is_pin: 1'b0, exp: exp});
      bus.cs = 1'b1; bus.oe = 1'b1; bus.address = a;
      tick();
      bus.cs = 1'b0; bus.oe = 1'b0;
   endtask

   task automatic pin_check(input string nm, input logic [31:0] exp);
      sb_q.push_back('{name: nm, is_pin: 1'b1, exp: exp});
      pin_smp = 1'b1;
      tick();
      pin_smp = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: act=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a5;
      a5 = 8'hA5;
      checks = 0; failures = 0;
      rst = 1'b0; bus.cs = 1'b0; bus.oe = 1'b0; bus.we = 4'd0; bus.address = 2'd0;
      tb_wdat = '0; tb_drv = 1'b0; pin_smp = 1'b0; miso_mode = 0;
      repeat (2) tick();
      rst = 1'b1;

      // Reset state
      pin_check("rst_pins", pw(0, 0, 0, 4'hF));
      bus_read("rst_ctrl", 2'd0, 32'h0);
      bus_read("rst_div",  2'd2, 32'h4);
      bus_read("rst_data", 2'd1, 32'h0);
      bus_read("rst_ssel", 2'd3, 32'h0);

      // Loopback A5 at CLKDIV=0
      bus_write(2'd2, 4'b0011, 32'h0);
      bus_write(2'd3, 4'b0001, 32'h1);
      pin_check("ssel_pins", pw(0, 0, 0, 4'hE));
      bus_write(2'd1, 4'b0001, 32'hA5);
      bus_read("lb_load_busy", 2'd0, 32'h8);
      tick();
      for (int k = 0; k < 8; k++) begin
         pin_check($sformatf("lb_bit%0d", k), pw(0, 1, a5[7-k], 4'hE));
         bus_read($sformatf("lb_busy%0d", k), 2'd0, 32'h8);
      end
      bus_read("lb_done",   2'd0, 32'h4);
      bus_read("lb_rx",     2'd1, 32'hA5);
      bus_read("lb_rdclr",  2'd0, 32'h0);

      // irq with miso high
      miso_mode = 1;
      bus_write(2'd0, 4'b0001, 32'h1);
      bus_write(2'd1, 4'b0001, 32'h00);
      repeat (17) tick();
      pin_check("irq_pre",  pw(0, 0, 0, 4'hE));
      pin_check("irq_rise", pw(1, 0, 0, 4'hE));
      bus_read("irq_ctrl", 2'd0, 32'h5);
      bus_write(2'd0, 4'b0001, 32'h5);
      pin_check("irq_w1c",  pw(0, 0, 0, 4'hE));
      bus_read("irq_rx",   2'd1, 32'hFF);
      bus_read("irq_ctrl2", 2'd0, 32'h1);

      // Overrun mid-transfer
      miso_mode = 0;
      bus_write(2'd1, 4'b0001, 32'h3C);
      repeat (4) tick();
      bus_write(2'd1, 4'b0001, 32'h11);
      bus_read("ovr_busy", 2'd0, 32'hB);
      repeat (12) tick();
      bus_read("ovr_done", 2'd0, 32'h7);
      bus_read("ovr_rx",   2'd1, 32'h3C);
      repeat (20) tick();
      bus_read("ovr_idle", 2'd0, 32'h3);

      // DATA write in the DONE cycle counts as overrun
      bus_write(2'd1, 4'b0001, 32'h5A);
      repeat (17) tick();
      bus_write(2'd1, 4'b0001, 32'h77);
      bus_read("dcyc_ctrl", 2'd0, 32'h7);
      bus_read("dcyc_rx",   2'd1, 32'h5A);
      bus_read("dcyc_idle", 2'd0, 32'h3);

      // W1C of DONE on the edge that sets it: set wins; OVR clears
      bus_write(2'd1, 4'b0001, 32'h0F);
      repeat (17) tick();
      bus_write(2'd0, 4'b0001, 32'h7);
      bus_read("setwin_ctrl", 2'd0, 32'h5);
      bus_read("setwin_rx",   2'd1, 32'h0F);
      bus_read("setwin_idle", 2'd0, 32'h1);

      // Byte-lane CLKDIV write and long transfer latency
      bus_write(2'd2, 4'b0011, 32'h0102);
      bus_write(2'd2, 4'b0001, 32'hFF);
      bus_read("div_lane", 2'd2, 32'h01FF);
      bus_write(2'd1, 4'b0001, 32'h81);
      repeat (8192) tick();
      bus_read("lat_m2",  2'd0, 32'h9);
      bus_read("lat_m1",  2'd0, 32'h9);
      bus_read("lat_end", 2'd0, 32'h5);
      bus_read("lat_rx",  2'd1, 32'h81);
      bus_write(2'd2, 4'b0011, 32'h0);

      // Reset during bit 4
      bus_write(2'd1, 4'b0001, 32'hF0);
      repeat (10) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      pin_check("abort_pins", pw(0, 0, 0, 4'hF));
      bus_read("abort_ctrl", 2'd0, 32'h0);
      bus_read("abort_rx",   2'd1, 32'h0);
      bus_read("abort_div",  2'd2, 32'h4);
      bus_read("abort_ssel", 2'd3, 32'h0);

      tick();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: act=%0d entries left required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
